// File: rtl/jpeg_color_pkg.sv
// Shared constants, pixel type and clamp helper for the JPEG colour-conversion path.
// Coefficients are scaled by 2^13; chroma is stored offset by 128.
package jpeg_color_pkg;

  localparam int FRAC_BITS_DEF = 13;

  localparam logic signed [14:0] CR_R = 15'sd11485;  // 1.402
  localparam logic signed [14:0] CB_G = 15'sd2819;   // 0.344136
  localparam logic signed [14:0] CR_G = 15'sd5850;   // 0.714136
  localparam logic signed [14:0] CB_B = 15'sd14516;  // 1.772

  localparam logic signed [23:0] ROUND_K    = 24'sd4096;
  localparam logic signed [8:0]  CHROMA_OFF = 9'sd128;

  // c0 carries Y or R, c1 carries Cb or G, c2 carries Cr or B
  typedef struct packed {
    logic [7:0] c2;
    logic [7:0] c1;
    logic [7:0] c0;
  } pix_t;

  function automatic logic [7:0] clamp_u8(input logic signed [23:0] v);
    if (v < 24'sd0) begin
      return 8'd0;
    end else if (v > 24'sd255) begin
      return 8'hFF;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/ycbcr2rgb.sv
// Three-stage full-range YCbCr -> RGB converter with valid/ready back-pressure.
// Optional saturation counter enabled by defining YCBCR2RGB_SAT_CNT_EN.
module ycbcr2rgb
  import jpeg_color_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      data_out,
  output logic [CNT_W-1:0] sat_count
);

  logic advance;

  pix_t             pix_in;
  logic signed [8:0] cb_s, cr_s;

  logic signed [23:0] y_p1_d, crr_p1_d, cbg_p1_d, crg_p1_d, cbb_p1_d;
  logic signed [23:0] y_p1_q, crr_p1_q, cbg_p1_q, crg_p1_q, cbb_p1_q;
  logic               vld_p1_q;

  logic signed [23:0] r_p2_d, g_p2_d, b_p2_d;
  logic signed [23:0] r_p2_q, g_p2_q, b_p2_q;
  logic               vld_p2_q;

  logic signed [23:0] r_sh, g_sh, b_sh;
  pix_t               rgb_p3_d;
  logic [23:0]        data_out_q;
  logic               out_valid_q;

  // The whole pipeline moves together; a held output freezes every stage.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  assign pix_in = data_in;
  assign cb_s   = signed'({1'b0, pix_in.c1}) - CHROMA_OFF;
  assign cr_s   = signed'({1'b0, pix_in.c2}) - CHROMA_OFF;

  always_comb begin
    // stage 1: scaled luma and chroma products
    y_p1_d   = signed'({16'd0, pix_in.c0}) <<< FRAC_BITS;
    crr_p1_d = 24'(CR_R) * 24'(cr_s);
    cbg_p1_d = 24'(CB_G) * 24'(cb_s);
    crg_p1_d = 24'(CR_G) * 24'(cr_s);
    cbb_p1_d = 24'(CB_B) * 24'(cb_s);

    // stage 2: rounded channel sums
    r_p2_d = y_p1_q + crr_p1_q + ROUND_K;
    g_p2_d = y_p1_q - cbg_p1_q - crg_p1_q + ROUND_K;
    b_p2_d = y_p1_q + cbb_p1_q + ROUND_K;

    // stage 3: drop fraction, clamp to 8 bits
    r_sh = r_p2_q >>> FRAC_BITS;
    g_sh = g_p2_q >>> FRAC_BITS;
    b_sh = b_p2_q >>> FRAC_BITS;

    rgb_p3_d.c0 = clamp_u8(r_sh);
    rgb_p3_d.c1 = clamp_u8(g_sh);
    rgb_p3_d.c2 = clamp_u8(b_sh);
  end

  // Internal datapath carries no reset; the valid chain marks what is live.
  always_ff @(posedge clk) begin
    if (advance) begin
      y_p1_q   <= y_p1_d;
      crr_p1_q <= crr_p1_d;
      cbg_p1_q <= cbg_p1_d;
      crg_p1_q <= crg_p1_d;
      cbb_p1_q <= cbb_p1_d;
      r_p2_q   <= r_p2_d;
      g_p2_q   <= g_p2_d;
      b_p2_q   <= b_p2_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else if (advance) begin
      vld_p1_q    <= in_valid;
      vld_p2_q    <= vld_p1_q;
      out_valid_q <= vld_p2_q;
      data_out_q  <= rgb_p3_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

`ifdef YCBCR2RGB_SAT_CNT_EN
  function automatic logic clamped(input logic signed [23:0] v);
    return (v < 24'sd0) || (v > 24'sd255);
  endfunction

  logic             sat_p3;
  logic [CNT_W-1:0] sat_cnt_d, sat_cnt_q;

  assign sat_p3 = clamped(r_sh) || clamped(g_sh) || clamped(b_sh);

  // Counted as a valid pixel enters the output register; sticks at all-ones.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (advance && vld_p2_q && sat_p3 && !(&sat_cnt_q)) begin
      sat_cnt_d = sat_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_count = sat_cnt_q;
`else
  assign sat_count = '0;
`endif

endmodule
